mlp_train_scheduler: RTL and testbench

MLP_TRAIN_SCHEDULER -- requirements
Module: mlp_train_scheduler

---
 rtl/mlp_train_scheduler.sv | 179 +++++++++++++++++
 tb/tb_mlp_train_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_train_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | mlp_train_scheduler : epoch/sample sequencer feeding an MLP one sample at a time. |
// | Optional: MLP_SCHED_LR_DECAY_EN halves the learning rate every DECAY_PERIOD epochs. |
// | Revision: 1.0                                                                     |
// +-----------------------------------------------------------------------------------+
module mlp_train_scheduler #(
   parameter int INPUTS        = 2,
   parameter int OUTPUTS       = 1,
   parameter int NUM_SAMPLES   = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int DECAY_PERIOD  = 8,
   localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [15:0]   num_epochs,
   input  real           base_lr,
   output logic          sample_rd_en,
   output logic [AW-1:0] sample_addr,
   input  real           sample_values   [INPUTS],
   input  real           sample_expected [OUTPUTS],
   output real           mlp_values      [INPUTS],
   output real           mlp_expected    [OUTPUTS],
   output logic          mlp_training,
   output real           mlp_learning_rate,
   output logic          busy,
   output logic          done,
   output logic [15:0]   epoch_count,
   output logic [AW-1:0] sample_index
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, APPLY, SETTLE, UPDATE, DONE} state_t;

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_SAMPLES - 1);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

`ifdef MLP_SCHED_LR_DECAY_EN
   localparam bit DECAY_EN = 1'b1;
`else
   localparam bit DECAY_EN = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [AW-1:0] sample_index_q, sample_index_d;
   logic [15:0]   epoch_count_q, epoch_count_d;
   logic [15:0]   num_epochs_q, num_epochs_d;
   logic [SW-1:0] settle_q, settle_d;
   real           mlp_values_q   [INPUTS];
   real           mlp_values_d   [INPUTS];
   real           mlp_expected_q [OUTPUTS];
   real           mlp_expected_d [OUTPUTS];
   real           lr_q, lr_d;

   logic [15:0] epoch_inc;
   logic        decay_hit;

   assign epoch_inc = epoch_count_q + 16'd1;
   // Decay is keyed on the post-increment epoch so the halving lands with the increment.
   assign decay_hit = DECAY_EN && (epoch_inc != 16'd0) &&
                      ((32'(epoch_inc) % DECAY_PERIOD) == 0);

   always_comb begin
      state_d        = state_q;
      sample_index_d = sample_index_q;
      epoch_count_d  = epoch_count_q;
      num_epochs_d   = num_epochs_q;
      settle_d       = settle_q;
      mlp_values_d   = mlp_values_q;
      mlp_expected_d = mlp_expected_q;
      lr_d           = lr_q;
      sample_rd_en   = 1'b0;
      sample_addr    = '0;
      mlp_training   = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_epochs == 16'd0) begin
                  state_d = DONE;
               end else begin
                  num_epochs_d   = num_epochs;
                  lr_d           = base_lr;
                  sample_index_d = '0;
                  epoch_count_d  = '0;
                  state_d        = FETCH;
               end
            end
         end
         FETCH: begin
            busy         = 1'b1;
            sample_rd_en = 1'b1;
            sample_addr  = sample_index_q;
            state_d      = WAIT;
         end
         WAIT: begin
            busy           = 1'b1;
            mlp_values_d   = sample_values;
            mlp_expected_d = sample_expected;
            state_d        = APPLY;
         end
         APPLY: begin
            busy     = 1'b1;
            settle_d = SETTLE_LOAD;
            state_d  = SETTLE;
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_q == '0) state_d = UPDATE;
            else                settle_d = settle_q - 1'b1;
         end
         UPDATE: begin
            busy         = 1'b1;
            mlp_training = 1'b1;
            if (sample_index_q != LAST_IDX) begin
               sample_index_d = sample_index_q + 1'b1;
               state_d        = FETCH;
            end else begin
               sample_index_d = '0;
               epoch_count_d  = epoch_inc;
               if (decay_hit) lr_d = lr_q * 0.5;
               state_d = (epoch_inc == num_epochs_q) ? DONE : FETCH;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort freezes all run state in place and suppresses the weight update.
      if (abort && busy) begin
         state_d        = IDLE;
         sample_index_d = sample_index_q;
         epoch_count_d  = epoch_count_q;
         settle_d       = settle_q;
         mlp_values_d   = mlp_values_q;
         mlp_expected_d = mlp_expected_q;
         lr_d           = lr_q;
         mlp_training   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         sample_index_q <= '0;
         epoch_count_q  <= '0;
         num_epochs_q   <= '0;
         settle_q       <= '0;
         for (int i = 0; i < INPUTS; i++)  mlp_values_q[i]   <= 0.0;
         for (int i = 0; i < OUTPUTS; i++) mlp_expected_q[i] <= 0.0;
         lr_q           <= 0.0;
      end else begin
         state_q        <= state_d;
         sample_index_q <= sample_index_d;
         epoch_count_q  <= epoch_count_d;
         num_epochs_q   <= num_epochs_d;
         settle_q       <= settle_d;
         mlp_values_q   <= mlp_values_d;
         mlp_expected_q <= mlp_expected_d;
         lr_q           <= lr_d;
      end
   end

   assign mlp_values        = mlp_values_q;
   assign mlp_expected      = mlp_expected_q;
   assign mlp_learning_rate = lr_q;
   assign epoch_count       = epoch_count_q;
   assign sample_index      = sample_index_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_train_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mlp_train_scheduler : scoreboard bench for mlp_train_scheduler.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mlp_train_scheduler;
   localparam int INPUTS = 2;
   localparam int OUTPUTS = 1;
   localparam int NS = 4;
   localparam int SC = 2;
   localparam int DP = 2;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [15:0]   num_epochs = '0;
   real           base_lr = 0.0;
   logic          sample_rd_en;
   logic [AW-1:0] sample_addr;
   real           sample_values   [INPUTS];
   real           sample_expected [OUTPUTS];
   real           mlp_values      [INPUTS];
   real           mlp_expected    [OUTPUTS];
   logic          mlp_training;
   real           mlp_learning_rate;
   logic          busy, done;
   logic [15:0]   epoch_count;
   logic [AW-1:0] sample_index;

   mlp_train_scheduler #(
      .INPUTS(INPUTS), .OUTPUTS(OUTPUTS), .NUM_SAMPLES(NS),
      .SETTLE_CYCLES(SC), .DECAY_PERIOD(DP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .num_epochs(num_epochs), .base_lr(base_lr),
      .sample_rd_en(sample_rd_en), .sample_addr(sample_addr),
      .sample_values(sample_values), .sample_expected(sample_expected),
      .mlp_values(mlp_values), .mlp_expected(mlp_expected),
      .mlp_training(mlp_training), .mlp_learning_rate(mlp_learning_rate),
      .busy(busy), .done(done), .epoch_count(epoch_count), .sample_index(sample_index)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int rd_cnt, train_cnt, done_cnt, busy_cnt;
   int first_rd_cyc, first_train_cyc, done_cyc;
   int rd_seq = 0;
   bit pending = 1'b0;
   int  exp_seq[$];
   int  exp_addr[$];
   int  obs_addr[$];
   int  obs_ep[$];
   real obs_v0[$];
   real obs_v1[$];
   real obs_e[$];
   real obs_lr[$];

   function automatic real lr_model(real b, int ep);
      real r = b;
`ifdef MLP_SCHED_LR_DECAY_EN
      for (int i = 1; i <= ep; i++) if (i % DP == 0) r = r / 2.0;
`endif
      return r;
   endfunction

   // One clock: dataset memory answers a read one cycle later; outputs sampled at negedge.
   task automatic step();
      @(posedge clk);
      #1;
      if (pending) begin
         rd_seq++;
         sample_values[0]   = 1.5 * rd_seq;
         sample_values[1]   = -1.0 * rd_seq;
         sample_expected[0] = rd_seq + 0.5;
         exp_seq.push_back(rd_seq);
         pending = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (sample_rd_en) begin
         if (rd_cnt == 0) first_rd_cyc = cyc;
         rd_cnt++;
         obs_addr.push_back(int'(sample_addr));
         pending = 1'b1;
      end
      if (mlp_training) begin
         if (train_cnt == 0) first_train_cyc = cyc;
         train_cnt++;
         obs_v0.push_back(mlp_values[0]);
         obs_v1.push_back(mlp_values[1]);
         obs_e.push_back(mlp_expected[0]);
         obs_lr.push_back(mlp_learning_rate);
         obs_ep.push_back(int'(epoch_count));
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
   endtask

   task automatic mon_clear();
      rd_cnt = 0; train_cnt = 0; done_cnt = 0; busy_cnt = 0;
      first_rd_cyc = -1; first_train_cyc = -1; done_cyc = -1;
      pending = 1'b0;
      exp_seq.delete(); exp_addr.delete(); obs_addr.delete(); obs_ep.delete();
      obs_v0.delete(); obs_v1.delete(); obs_e.delete(); obs_lr.delete();
   endtask

   task automatic pulse_start(input logic [15:0] e, input real lr);
      num_epochs = e;
      base_lr    = lr;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (sample_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", sample_rd_en); end
      n_checks++; if (mlp_training !== 1'b0) begin n_fail++; $display("FAIL reset_training got %b want 0", mlp_training); end
      n_checks++; if (sample_addr !== 2'd0 || sample_index !== 2'd0) begin n_fail++; $display("FAIL reset_addr_idx got %0d/%0d want 0/0", sample_addr, sample_index); end
      n_checks++; if (epoch_count !== 16'd0) begin n_fail++; $display("FAIL reset_epoch got %0d want 0", epoch_count); end
      n_checks++; if (mlp_values[0] != 0.0 || mlp_values[1] != 0.0 || mlp_expected[0] != 0.0 || mlp_learning_rate != 0.0) begin
         n_fail++; $display("FAIL reset_reals got %f %f %f %f want all 0.0", mlp_values[0], mlp_values[1], mlp_expected[0], mlp_learning_rate);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_full_run(input int epochs, input real lr);
      int es;
      int got;
      mon_clear();
      for (int e = 0; e < epochs; e++) for (int a = 0; a < NS; a++) exp_addr.push_back(a);
      pulse_start(16'(epochs), lr);
      for (int k = 0; k < 400 && done_cnt == 0; k++) step();
      n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL run_done got %0d pulses want 1", done_cnt); end
      n_checks++; if (train_cnt !== epochs * NS) begin n_fail++; $display("FAIL run_train_cnt got %0d want %0d", train_cnt, epochs * NS); end
      n_checks++; if (obs_addr.size() !== exp_addr.size()) begin n_fail++; $display("FAIL run_rd_cnt got %0d want %0d", obs_addr.size(), exp_addr.size()); end
      for (int i = 0; i < exp_addr.size(); i++) begin
         got = (i < obs_addr.size()) ? obs_addr[i] : -1;
         n_checks++; if (got !== exp_addr[i]) begin n_fail++; $display("FAIL run_addr[%0d] got %0d want %0d", i, got, exp_addr[i]); end
      end
      for (int i = 0; i < obs_v0.size(); i++) begin
         es = (exp_seq.size() > 0) ? exp_seq.pop_front() : -999;
         n_checks++;
         if (obs_v0[i] != 1.5 * es || obs_v1[i] != -1.0 * es || obs_e[i] != es + 0.5) begin
            n_fail++; $display("FAIL run_stimulus[%0d] got %f %f %f want %f %f %f", i, obs_v0[i], obs_v1[i], obs_e[i], 1.5 * es, -1.0 * es, es + 0.5);
         end
         n_checks++; if (obs_lr[i] != lr_model(lr, obs_ep[i])) begin n_fail++; $display("FAIL run_lr[%0d] got %f want %f", i, obs_lr[i], lr_model(lr, obs_ep[i])); end
      end
      n_checks++; if (first_train_cyc - first_rd_cyc !== SC + 3) begin n_fail++; $display("FAIL run_sample_latency got %0d want %0d", first_train_cyc - first_rd_cyc, SC + 3); end
      n_checks++; if (done_cyc - first_rd_cyc !== epochs * NS * (SC + 4)) begin n_fail++; $display("FAIL run_done_latency got %0d want %0d", done_cyc - first_rd_cyc, epochs * NS * (SC + 4)); end
      n_checks++; if (epoch_count !== 16'(epochs)) begin n_fail++; $display("FAIL run_epoch got %0d want %0d", epoch_count, epochs); end
      step(); step(); step();
      n_checks++; if (done_cnt !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL run_after_done got done_cnt=%0d busy=%b want 1/0", done_cnt, busy); end
      n_checks++; if (epoch_count !== 16'(epochs) || mlp_values[0] != 1.5 * rd_seq) begin
         n_fail++; $display("FAIL run_hold got epoch=%0d v0=%f want %0d/%f", epoch_count, mlp_values[0], epochs, 1.5 * rd_seq);
      end
      n_checks++; if (mlp_learning_rate != lr_model(lr, epochs)) begin n_fail++; $display("FAIL run_final_lr got %f want %f", mlp_learning_rate, lr_model(lr, epochs)); end
   endtask

   task automatic test_zero_epochs();
      logic [15:0] prev_epoch;
      real prev_lr;
      prev_epoch = epoch_count;
      prev_lr    = mlp_learning_rate;
      mon_clear();
      pulse_start(16'd0, 0.3);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_next got %b want 1", done); end
      step(); step(); step();
      n_checks++; if (done_cnt !== 1 || rd_cnt !== 0 || busy_cnt !== 0) begin
         n_fail++; $display("FAIL zero_activity got done=%0d rd=%0d busy=%0d want 1/0/0", done_cnt, rd_cnt, busy_cnt);
      end
      n_checks++; if (epoch_count !== prev_epoch || mlp_learning_rate != prev_lr) begin
         n_fail++; $display("FAIL zero_hold got epoch=%0d lr=%f want %0d/%f", epoch_count, mlp_learning_rate, prev_epoch, prev_lr);
      end
   endtask

   task automatic test_start_ignored();
      int got;
      mon_clear();
      for (int e = 0; e < 2; e++) for (int a = 0; a < NS; a++) exp_addr.push_back(a);
      pulse_start(16'd2, 1.25);
      num_epochs = 16'd1;
      for (int k = 0; k < 200 && done_cnt == 0; k++) begin
         start = (k % 7 == 3);
         step();
      end
      start = 1'b0;
      n_checks++; if (done_cnt !== 1 || train_cnt !== 2 * NS) begin n_fail++; $display("FAIL busy_start_counts got done=%0d train=%0d want 1/%0d", done_cnt, train_cnt, 2 * NS); end
      n_checks++; if (epoch_count !== 16'd2) begin n_fail++; $display("FAIL busy_start_epoch got %0d want 2", epoch_count); end
      n_checks++; if (done_cyc - first_rd_cyc !== 2 * NS * (SC + 4)) begin n_fail++; $display("FAIL busy_start_latency got %0d want %0d", done_cyc - first_rd_cyc, 2 * NS * (SC + 4)); end
      for (int i = 0; i < exp_addr.size(); i++) begin
         got = (i < obs_addr.size()) ? obs_addr[i] : -1;
         n_checks++; if (got !== exp_addr[i]) begin n_fail++; $display("FAIL busy_start_addr[%0d] got %0d want %0d", i, got, exp_addr[i]); end
      end
      step(); step();
   endtask

   task automatic test_abort();
      bit found = 1'b0;
      int tr_snap;
      mon_clear();
      pulse_start(16'd3, 0.5);
      for (int k = 0; k < 200 && !found; k++) begin
         step();
         if (sample_rd_en && sample_addr == 2'd2 && epoch_count == 16'd1) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL abort_reach got no fetch of sample 2 epoch 1 want one"); end
      step(); step(); step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      tr_snap = train_cnt;
      n_checks++; if (busy !== 1'b0 || tr_snap !== NS + 2) begin n_fail++; $display("FAIL abort_idle got busy=%b train=%0d want 0/%0d", busy, tr_snap, NS + 2); end
      for (int k = 0; k < 20; k++) step();
      n_checks++; if (train_cnt !== tr_snap || done_cnt !== 0) begin n_fail++; $display("FAIL abort_quiet got train=%0d done=%0d want %0d/0", train_cnt, done_cnt, tr_snap); end
      n_checks++; if (epoch_count !== 16'd1 || sample_index !== 2'd2) begin n_fail++; $display("FAIL abort_counters got epoch=%0d idx=%0d want 1/2", epoch_count, sample_index); end
   endtask

   task automatic test_reset_update();
      int busy_snap;
      mon_clear();
      pulse_start(16'd2, 0.5);
      for (int k = 0; k < 60 && train_cnt < 2; k++) step();
      n_checks++; if (mlp_training !== 1'b1) begin n_fail++; $display("FAIL rst_reach got training=%b want 1", mlp_training); end
      rst = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b0 || mlp_training !== 1'b0 || done !== 1'b0 || sample_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL rst_async_ctrl got busy=%b train=%b done=%b rd=%b want 0", busy, mlp_training, done, sample_rd_en);
      end
      n_checks++; if (epoch_count !== 16'd0 || sample_index !== 2'd0 || sample_addr !== 2'd0) begin
         n_fail++; $display("FAIL rst_async_cnt got epoch=%0d idx=%0d addr=%0d want 0", epoch_count, sample_index, sample_addr);
      end
      n_checks++; if (mlp_values[0] != 0.0 || mlp_expected[0] != 0.0 || mlp_learning_rate != 0.0) begin
         n_fail++; $display("FAIL rst_async_reals got %f %f %f want 0.0", mlp_values[0], mlp_expected[0], mlp_learning_rate);
      end
      step();
      rst = 1'b0;
      busy_snap = busy_cnt;
      for (int k = 0; k < 10; k++) step();
      n_checks++; if (done_cnt !== 0 || busy_cnt !== busy_snap) begin n_fail++; $display("FAIL rst_quiet got done=%0d busy_cycles=%0d want 0/%0d", done_cnt, busy_cnt, busy_snap); end
   endtask

   task automatic test_lr_decay();
      mon_clear();
      pulse_start(16'd5, 0.5);
      for (int k = 0; k < 300 && done_cnt == 0; k++) step();
      n_checks++; if (done_cnt !== 1 || train_cnt !== 5 * NS) begin n_fail++; $display("FAIL decay_counts got done=%0d train=%0d want 1/%0d", done_cnt, train_cnt, 5 * NS); end
      for (int i = 0; i < obs_lr.size(); i++) begin
         n_checks++; if (obs_lr[i] != lr_model(0.5, obs_ep[i])) begin n_fail++; $display("FAIL decay_lr[%0d] got %f want %f", i, obs_lr[i], lr_model(0.5, obs_ep[i])); end
      end
`ifdef MLP_SCHED_LR_DECAY_EN
      n_checks++; if (mlp_learning_rate != 0.125) begin n_fail++; $display("FAIL decay_final got %f want 0.125", mlp_learning_rate); end
`else
      n_checks++; if (mlp_learning_rate != 0.5) begin n_fail++; $display("FAIL decay_final got %f want 0.5", mlp_learning_rate); end
`endif
   endtask

   initial begin
      for (int i = 0; i < INPUTS; i++)  sample_values[i] = 0.0;
      for (int i = 0; i < OUTPUTS; i++) sample_expected[i] = 0.0;
      mon_clear();
      test_reset();
      test_full_run(3, 0.75);
      test_zero_epochs();
      test_start_ignored();
      test_abort();
      test_reset_update();
      test_full_run(1, 2.0);
      test_lr_decay();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
